// File: rtl/vga_pkg.sv
// +--------------------------------------------------------------------------+
// | vga_pkg : shared cell geometry, attribute layout and pipeline depth      |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int c_cell_w         = 8;
  localparam int c_cell_h         = 16;
  localparam int c_cell_w_log2    = 3;
  localparam int c_cell_h_log2    = 4;

  localparam int c_attr_fg_lsb    = 0;
  localparam int c_attr_bg_lsb    = 4;
  localparam int c_attr_blink_bit = 7;

  localparam int c_pipe_stages    = 3;

  localparam logic [3:0] c_cursor_line_first = 4'd14;

  // Underline cursor occupies the bottom two glyph lines of the cell.
  function automatic logic is_cursor_line(input logic [3:0] glyph_row);
    return glyph_row >= c_cursor_line_first;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_text_pipe_reg.sv
// +--------------------------------------------------------------------------+
// | vga_text_pipe_reg : one pipeline stage, parameterised width, async clear |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_text_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else     r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/vga_text_render.sv
// +--------------------------------------------------------------------------+
// | vga_text_render : 3-stage text-mode pixel pipeline (text RAM -> font ROM |
// | -> palette indices). Optional blink/frame counter: VGA_TEXT_BLINK_EN.    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module vga_text_render
  import vga_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        de_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic [11:0] tram_addr,
  input  logic [15:0] tram_rdata,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_rdata,
  input  logic [6:0]  cursor_col,
  input  logic [4:0]  cursor_row,
  input  logic        cursor_en,
  output logic [3:0]  fg,
  output logic [3:0]  bg,
  output logic        pix_on,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o
);

  localparam int c_s1_w = 11;
  localparam int c_s2_w = 15;
  localparam int c_s3_w = 12;

  // ---------------- stage 0: address generation and cursor hit ----------------
  logic [6:0] w_col0;
  logic [4:0] w_row0;
  logic       w_cur_hit0;

  assign w_col0    = hpos[9:c_cell_w_log2];
  assign w_row0    = vpos[8:c_cell_h_log2];
  assign tram_addr = 12'(w_row0) * 12'(COLS) + 12'(w_col0);

  assign w_cur_hit0 = cursor_en && (w_col0 == cursor_col) && (w_row0 == cursor_row)
                      && is_cursor_line(vpos[3:0]);

  // ---------------- stage 1: text RAM data arrives, font lookup ---------------
  logic [c_s1_w-1:0] w_s1_d, w_s1_q;
  logic [3:0]        w_s1_vlo;
  logic [2:0]        w_s1_hlo;
  logic              w_s1_cur, w_s1_de, w_s1_hs, w_s1_vs;

  assign w_s1_d = {vpos[3:0], hpos[2:0], w_cur_hit0, de_i, hsync_i, vsync_i};

  vga_text_pipe_reg #(.WIDTH(c_s1_w)) u_stage1 (
    .clk (clk),
    .rst (rst),
    .i_d (w_s1_d),
    .o_q (w_s1_q)
  );

  assign {w_s1_vlo, w_s1_hlo, w_s1_cur, w_s1_de, w_s1_hs, w_s1_vs} = w_s1_q;
  assign font_addr = {tram_rdata[7:0], w_s1_vlo};

  // ---------------- stage 2: glyph bit select and attribute decode ------------
  logic [c_s2_w-1:0] w_s2_d, w_s2_q;
  logic [7:0]        w_s2_attr;
  logic [2:0]        w_s2_hlo;
  logic              w_s2_cur, w_s2_de, w_s2_hs, w_s2_vs;

  assign w_s2_d = {tram_rdata[15:8], w_s1_hlo, w_s1_cur, w_s1_de, w_s1_hs, w_s1_vs};

  vga_text_pipe_reg #(.WIDTH(c_s2_w)) u_stage2 (
    .clk (clk),
    .rst (rst),
    .i_d (w_s2_d),
    .o_q (w_s2_q)
  );

  assign {w_s2_attr, w_s2_hlo, w_s2_cur, w_s2_de, w_s2_hs, w_s2_vs} = w_s2_q;

  logic       w_glyph_bit;
  logic       w_pix;
  logic [3:0] w_fg;
  logic [3:0] w_bg;

  assign w_glyph_bit = font_rdata[3'd7 - w_s2_hlo];
  assign w_fg        = w_s2_attr[c_attr_fg_lsb +: 4];

`ifdef VGA_TEXT_BLINK_EN
  logic       r_vsync_prev;
  logic [4:0] r_frame_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
      r_frame_cnt  <= 5'd0;
    end else begin
      r_vsync_prev <= vsync_i;
      if (vsync_i && !r_vsync_prev) r_frame_cnt <= r_frame_cnt + 5'd1;
    end
  end

  // Blinking text is off for the upper half of the 32-frame cycle; cursor flashes twice as fast.
  assign w_pix = (w_glyph_bit & ~(w_s2_attr[c_attr_blink_bit] & r_frame_cnt[4]))
                 | (w_s2_cur & r_frame_cnt[3]);
  assign w_bg  = {1'b0, w_s2_attr[c_attr_bg_lsb +: 3]};
`else
  assign w_pix = w_glyph_bit | w_s2_cur;
  assign w_bg  = w_s2_attr[c_attr_bg_lsb +: 4];
`endif

  // ---------------- stage 3: blanking mask and output register -----------------
  logic [c_s3_w-1:0] w_s3_d, w_s3_q;

  assign w_s3_d = w_s2_de ? {w_fg, w_bg, w_pix, 1'b1, w_s2_hs, w_s2_vs}
                          : {4'd0, 4'd0, 1'b0, 1'b0, w_s2_hs, w_s2_vs};

  vga_text_pipe_reg #(.WIDTH(c_s3_w)) u_stage3 (
    .clk (clk),
    .rst (rst),
    .i_d (w_s3_d),
    .o_q (w_s3_q)
  );

  assign {fg, bg, pix_on, de_o, hsync_o, vsync_o} = w_s3_q;

  // Off-screen rows and the top position bit never reach an address.
  logic w_unused;
`ifdef VGA_TEXT_BLINK_EN
  assign w_unused = ^{vpos[9], (w_row0 >= 5'(ROWS)), r_frame_cnt[2:0]};
`else
  assign w_unused = ^{vpos[9], (w_row0 >= 5'(ROWS))};
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_text_render.sv
// +--------------------------------------------------------------------------+
// | tb_vga_text_render : directed self-checking bench for vga_text_render    |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vga_text_render;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  hpos = '0, vpos = '0;
  logic        de_i = 1'b0, hsync_i = 1'b0, vsync_i = 1'b0;
  logic [11:0] tram_addr, font_addr;
  logic [15:0] tram_rdata;
  logic [7:0]  font_rdata;
  logic [6:0]  cursor_col = '0;
  logic [4:0]  cursor_row = '0;
  logic        cursor_en = 1'b0;
  logic [3:0]  fg, bg;
  logic        pix_on, de_o, hsync_o, vsync_o;

  logic [11:0] w_out;
  assign w_out = {fg, bg, pix_on, de_o, hsync_o, vsync_o};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_text_render #(.COLS(80), .ROWS(30)) dut (
    .clk        (clk),
    .rst        (rst),
    .hpos       (hpos),
    .vpos       (vpos),
    .de_i       (de_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .tram_addr  (tram_addr),
    .tram_rdata (tram_rdata),
    .font_addr  (font_addr),
    .font_rdata (font_rdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .cursor_en  (cursor_en),
    .fg         (fg),
    .bg         (bg),
    .pix_on     (pix_on),
    .de_o       (de_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o)
  );

  // Synchronous-read text RAM and font ROM models.
  logic [15:0] tram [0:4095];
  logic [7:0]  font [0:4095];

  always @(posedge clk) begin
    tram_rdata <= tram[tram_addr];
    font_rdata <= font[font_addr];
  end

  task automatic apply(input logic [9:0] h, input logic [9:0] v,
                       input logic de, input logic hs, input logic vs);
    hpos = h; vpos = v; de_i = de; hsync_i = hs; vsync_i = vs;
  endtask

  task automatic pulse_vsync();
    apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(10'd3, 10'd0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (w_out !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", w_out, 12'h000);
    end
    apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_glyph();
    logic [7:0]  glyph;
    logic [11:0] exp;
    glyph = 8'h18;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (i >= 3) begin
        exp = {4'hE, 4'h1, glyph[7 - (i - 3)], 1'b1, 1'b0, 1'b0};
        n_checks++;
        if (w_out !== exp) begin
          n_fail++;
          $display("FAIL glyph_px%0d: got %h expected %h", i - 3, w_out, exp);
        end
      end
      if (i < 8) apply(10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
      else       apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_addr_edge();
    logic [11:0] exp_twin;
`ifdef VGA_TEXT_BLINK_EN
    exp_twin = {4'hF, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    exp_twin = {4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0};
`endif
    apply(10'd639, 10'd479, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (tram_addr !== 12'd2399) begin
      n_fail++;
      $display("FAIL addr_last_cell: got %0d expected %0d", tram_addr, 2399);
    end
    apply(10'd45, 10'd37, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (tram_addr !== 12'd165) begin
      n_fail++;
      $display("FAIL addr_cell_5_2: got %0d expected %0d", tram_addr, 165);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin
        n_checks++;
        if (w_out !== 12'h002) begin
          n_fail++;
          $display("FAIL blank_mask: got %h expected %h", w_out, 12'h002);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (w_out !== exp_twin) begin
          n_fail++;
          $display("FAIL blank_twin_visible: got %h expected %h", w_out, exp_twin);
        end
      end
      if (i == 0)      apply(10'd639, 10'd479, 1'b0, 1'b1, 1'b0);
      else if (i == 1) apply(10'd639, 10'd479, 1'b1, 1'b0, 1'b0);
      else             apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_cursor();
    logic [11:0] exp_q [32];
    logic        vis;
    int          seg, x;
`ifdef VGA_TEXT_BLINK_EN
    int          passes = 2;
`else
    int          passes = 1;
`endif
    cursor_col = 7'd5; cursor_row = 5'd2; cursor_en = 1'b1;
    for (int pass = 0; pass < passes; pass++) begin
      vis = (pass == passes - 1);
      if (pass == 1) repeat (8) pulse_vsync();
      for (int i = 0; i < 35; i++) begin
        @(posedge clk); #1;
        if (i >= 3) begin
          n_checks++;
          if (w_out !== exp_q[i - 3]) begin
            n_fail++;
            $display("FAIL cursor_p%0d_i%0d: got %h expected %h", pass, i - 3, w_out, exp_q[i - 3]);
          end
        end
        if (i < 32) begin
          seg = i / 8; x = i % 8;
          case (seg)
            0: begin apply(10'(40 + x), 10'd46, 1'b1, 1'b0, 1'b0); exp_q[i] = {4'h7, 4'h0, vis, 3'b100}; end
            1: begin apply(10'(40 + x), 10'd47, 1'b1, 1'b0, 1'b0); exp_q[i] = {4'h7, 4'h0, vis, 3'b100}; end
            2: begin apply(10'(40 + x), 10'd45, 1'b1, 1'b0, 1'b0); exp_q[i] = {4'h7, 4'h0, 1'b0, 3'b100}; end
            default: begin apply(10'(48 + x), 10'd46, 1'b1, 1'b0, 1'b0); exp_q[i] = {4'h0, 4'h0, 1'b0, 3'b100}; end
          endcase
        end else begin
          apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        end
      end
    end
    cursor_en = 1'b0;
  endtask

  task automatic test_blink();
`ifdef VGA_TEXT_BLINK_EN
    int          steps   [6] = '{8, -1, 15, 1, 15, 1};
    logic        exp_pix [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [11:0] exp;
    for (int s = 0; s < 6; s++) begin
      if (steps[s] < 0) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else begin
        repeat (steps[s]) pulse_vsync();
      end
      apply(10'd80, 10'd0, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
      apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      exp = {4'hF, 4'h1, exp_pix[s], 3'b100};
      n_checks++;
      if (w_out !== exp) begin
        n_fail++;
        $display("FAIL blink_step%0d: got %h expected %h", s, w_out, exp);
      end
    end
`endif
  endtask

  task automatic test_reset_midline();
    logic [7:0]  glyph;
    logic [11:0] exp;
    glyph = 8'h18;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      apply(10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if ({fg, bg, de_o} !== 9'h1C3) begin
      n_fail++;
      $display("FAIL midline_pre_reset: got %h expected %h", {fg, bg, de_o}, 9'h1C3);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (w_out !== 12'h000) begin
      n_fail++;
      $display("FAIL midline_async_clear: got %h expected %h", w_out, 12'h000);
    end
    @(posedge clk); #1;
    n_checks++;
    if (w_out !== 12'h000) begin
      n_fail++;
      $display("FAIL midline_hold: got %h expected %h", w_out, 12'h000);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) apply(10'(i), 10'd0, 1'b1, 1'(i % 2), 1'((i / 2) % 2));
      else       apply(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      if (i < 2) exp = 12'h000;
      else       exp = {4'hE, 4'h1, glyph[7 - (i - 2)], 1'b1, 1'((i - 2) % 2), 1'(((i - 2) / 2) % 2)};
      n_checks++;
      if (w_out !== exp) begin
        n_fail++;
        $display("FAIL midline_recover%0d: got %h expected %h", i, w_out, exp);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin
      tram[a] = 16'h0000;
      font[a] = 8'h00;
    end
    tram[0]     = 16'h1E41;
    font[12'h410] = 8'h18;
    tram[2399]  = 16'hFFFF;
    font[12'hFFF] = 8'hFF;
    tram[165]   = 16'h0720;
    tram[10]    = 16'h9FDB;
    font[12'hDB0] = 8'hFF;

    test_reset();
    test_glyph();
    test_addr_edge();
    test_cursor();
    test_blink();
    test_reset_midline();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
